rr_arb8_ctrl: RTL
=================

Name: rr_arb8_ctrl

Overview:
- Sequenced round-robin arbiter that shares one datapath resource among 8 requesters.
- Picks a single winner by 3-bit index and drives a registered one-hot grant vector decoded from that index.
- Holds the grant until the winner releases it or a hold timeout expires, then inserts one turnaround cycle.
- Sits between the requester bank and the shared resource's select/enable lines.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8, 3-bit index.
- IDX_W, 3, width of the grant index.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; low blocks new grants, an active grant is unaffected.
- req  in  8  per-requester request, level-sensitive.
- done  in  8  per-requester release strobe; only the bit of the current winner is honoured.
- gnt  out  8  registered one-hot grant; all zero when no grant is active.
- gnt_idx  out  3  index of the current or last winner.
- gnt_valid  out  1  high while gnt is non-zero.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset values (asynchronous): state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, hold counter=0, round-robin pointer last=7, so the first search starts at index 0.
- States: IDLE, GRANT, GAP.
- Pick function (combinational): first set bit of req searching last+1, last+2, … mod 8.
- IDLE, en=1 and req!=0: at the next edge go to GRANT. gnt=one-hot(pick), gnt_idx=pick, gnt_valid=1, last=pick, counter=0. Latency from req to gnt is 1 cycle.
- IDLE, otherwise: stay in IDLE, outputs 0, gnt_idx holds.
- GRANT: counter increments every cycle. Release condition is done[gnt_idx]=1, req[gnt_idx]=0, or counter==MAX_HOLD-1.
  - On release, go to GAP at the next edge: gnt=0, gnt_valid=0.
  - timeout=1 for that same single cycle only if the counter reached MAX_HOLD-1 without done and with req still high.
  - If done and the timeout limit coincide, done wins and timeout stays 0.
- Grant duration: minimum 1 cycle, maximum MAX_HOLD cycles.
- In GRANT, done bits and req changes of non-winners are ignored.
- GAP: exactly one cycle with gnt=0 (bus turnaround). At the next edge:
  - if en=1 and req!=0, go directly to GRANT with a new pick;
  - otherwise go to IDLE.
  - Release in cycle t gives gnt low in t+1 and the next gnt high in t+2.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,…,7,0. The releasing requester is searched last on the next pick.
- A sole requester that re-requests after GAP is granted again.
- en deasserted in GRANT: the grant continues to natural release; then GAP→IDLE and no new grant until en=1.
- done asserted in IDLE or GAP: ignored.
- rst mid-grant: gnt drops immediately (asynchronous); pointer returns to 7.
- All outputs are registered; there is no combinational path from req or done to gnt.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - constants N_REQ=8 and IDX_W=3;
  - default MAX_HOLD.
- Sub-module rr_pick8: combinational rotate-priority picker. Inputs are req[7:0] and last[2:0]; outputs are idx[2:0] and any. It is instantiated once.
- The one-hot grant is formed by a 3-to-8 decode of the registered index.

Test Plan:
- Reset, then req=8'h01, en=1 → gnt=8'h01 one cycle later. Hold until done[0] pulses → gnt=0 for 1 cycle (GAP) → IDLE when req=0.
- req=8'hFF held continuously, each winner pulses done one cycle after its grant → gnt sequence 01,02,04,…,80,01. Exactly one zero cycle between grants.
- req=8'h05, never done → gnt=8'h01 for 16 cycles, timeout pulse coincident with gnt dropping, then gnt=8'h04 after GAP.
- done[0] and the timeout limit in the same cycle with gnt_idx=0 → release with timeout=0. A stray done[3] while idx=0 → no effect.
- en=0 with req=8'h10 → gnt stays 0. Raise en → gnt=8'h10 next cycle. Drop en mid-grant → grant persists until done[4], then IDLE.
- Assert rst asynchronously during gnt=8'h08 → gnt=0 immediately. After release with req=8'hFF → first grant is 8'h01.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: widths, state encoding
// and the index-to-one-hot decode used to form the grant vector.
package rr_arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = {N_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb8_ctrl_if.sv
// Requester-bank / arbiter handshake bundle: requests, releases and the grant outputs.
interface rr_arb8_ctrl_if;
    import rr_arb_pkg::*;

    logic               en;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request bit searching
// upward from the slot just after the previous winner, wrapping mod 8.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand_s;

    // Scan last+1 .. last+8; the previous winner is examined last
    always_comb begin
        idx    = {IDX_W{1'b0}};
        any    = 1'b0;
        cand_s = last;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = last + IDX_W'(i);
            idx    = (!any && req[cand_s]) ? cand_s : idx;
            any    = any | req[cand_s];
        end
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Sequenced round-robin arbiter for one shared resource: IDLE -> GRANT -> GAP,
// grant held until release or hold limit, one turnaround cycle between owners.
module rr_arb8_ctrl
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    rr_arb8_ctrl_if.slave   bus
);

    state_t             state_r;
    logic [IDX_W-1:0]   last_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [N_REQ-1:0]   gnt_r;
    logic [IDX_W-1:0]   gnt_idx_r;
    logic               gnt_valid_r;
    logic               timeout_r;

    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               win_done_s;
    logic               win_req_s;
    logic               limit_s;
    logic               release_s;
    logic               force_s;

    rr_pick8 u_pick (
        .req  (bus.req),
        .last (last_r),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Release decode for the current winner; only its own done/req bits matter
    always_comb begin
        win_done_s = bus.done[gnt_idx_r];
        win_req_s  = bus.req[gnt_idx_r];
        limit_s    = (cnt_r == CNT_W'(MAX_HOLD - 1));
        release_s  = win_done_s | ~win_req_s | limit_s;
        force_s    = limit_s & ~win_done_s & win_req_s;
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= 3'd7;
            cnt_r       <= {CNT_W{1'b0}};
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_GAP: begin
                    timeout_r <= 1'b0;
                    if (bus.en && pick_any_s) begin
                        state_r     <= ST_GRANT;
                        gnt_r       <= onehot8(pick_idx_s);
                        gnt_idx_r   <= pick_idx_s;
                        gnt_valid_r <= 1'b1;
                        last_r      <= pick_idx_s;
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (release_s) begin
                        state_r     <= ST_GAP;
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                        timeout_r   <= force_s;
                    end else begin
                        timeout_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= 8'h00;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = gnt_idx_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule
